versat_databus_arbiter: RTL
===========================

// Module: versat_databus_arbiter
// PURPOSE
//  Shares one external databus port among N_MASTERS Versat IO units (VRead/VWrite style databus_* masters).
//  Grants whole bursts with round-robin fairness; the grant is locked until the final beat (valid&ready&last) completes.
//  Sits between the IO units' databus_*_k ports and the single system-memory databus slave.
// PARAMETERS
//  N_MASTERS  2            number of requesting IO units (2..8)
//  DATA_W     32           databus data width
//  ADDR_W     `IO_ADDR_W   databus address width
//  IDX_W      $clog2(N_MASTERS)  grant index width (localparam, min 1)
// PORTS
//  clk           input   1                  clock
//  rst           input   1                  async reset, active-low (asserted at 0)
//  s_valid       input   N_MASTERS          per-master request/beat valid
//  s_ready       output  N_MASTERS          per-master beat accepted
//  s_addr        input   N_MASTERS*ADDR_W   per-master address, master k at [k*ADDR_W +: ADDR_W]
//  s_wdata       input   N_MASTERS*DATA_W   per-master write data
//  s_wstrb       input   N_MASTERS*DATA_W/8 per-master byte strobes (all-zero = read)
//  s_len         input   N_MASTERS*8        per-master burst length field, passed through
//  s_rdata       output  DATA_W             read data, broadcast to all masters
//  s_last        output  N_MASTERS          last-beat flag, gated to granted master
//  m_valid       output  1                  to memory: beat valid
//  m_ready       input   1                  from memory: beat accepted
//  m_addr/m_wdata/m_wstrb/m_len  output  ADDR_W/DATA_W/DATA_W/8/8  muxed from granted master
//  m_rdata       input   DATA_W             from memory
//  m_last        input   1                  from memory: final beat of burst
//  busy          output  1                  1 while in BURST
//  grant_idx     output  IDX_W              current/last granted master
// BEHAVIOUR
//  FSM states IDLE, BURST; reset -> IDLE, grant_idx=0, rr_ptr=0, busy=0, m_valid=0, s_ready=0, s_last=0.
//  IDLE: if any s_valid, pick winner (round-robin from rr_ptr, lowest index >= rr_ptr, wrap), register grant_idx, -> BURST.
//   Arbitration latency 1 cycle: m_valid cannot assert in the cycle the request first appears.
//  BURST: m_valid = s_valid[grant_idx]; m_addr/wdata/wstrb/len = granted master's fields; s_ready[g] = m_ready; others 0.
//   s_last[g] = m_last; s_rdata = m_rdata always (ungated).
//   Granted master may drop s_valid between beats; grant held, m_valid follows it (no re-arbitration).
//   On m_valid&m_ready&m_last: -> IDLE, rr_ptr = (grant_idx+1) mod N_MASTERS (wrap for non-power-of-2 N).
//   Exactly one IDLE cycle between consecutive bursts; no back-to-back grant.
//  m_last without m_valid&m_ready is ignored. m_valid/m_addr are 0 when not BURST.
//  Simultaneous requests: RR order only; a master that just finished is lowest priority next round.
//  Reset mid-burst: immediate return to IDLE, outputs to reset values; in-flight burst abandoned, no recovery.
//  Ungranted masters see s_ready=0 and s_last=0 indefinitely; no timeout.
// CONFIGURATION
//  VERSAT_ARB_PRIO_EN defined: extra input high_prio [N_MASTERS-1:0]; in IDLE, if any s_valid&high_prio,
//   round-robin among those only; else round-robin among all. rr_ptr update unchanged. Locked bursts never preempted.
//  Undefined: port absent, pure round-robin as above.
// STRUCTURE
//  IO_ADDR_W stays in versat-io.vh; new header versat-arb.vh holds ARB_IDLE/ARB_BURST state encodings.
//  Sub-module versat_rr_picker (combinational): req[N], ptr[IDX_W] -> found, idx[IDX_W]; instantiated once
//   (twice-masked input when VERSAT_ARB_PRIO_EN).
//  Top holds FSM, grant/rr_ptr registers and the output muxes.
// TESTING
//  1) Reset low with s_valid=2'b11 -> all outputs 0; release -> grant_idx=0, busy=1 after 1 cycle, m_valid=1 next.
//  2) N=2, both request 4-beat bursts (m_last on beat 4) -> master0 burst, 1 idle cycle, master1 burst, s_ready only to grantee.
//  3) Master0 alone does 3 consecutive bursts -> each granted after 1 IDLE cycle despite rr_ptr=1.
//  4) N=3, masters 0 and 2 request with rr_ptr=1 -> master2 wins; rr_ptr becomes 0 after its last beat.
//  5) Granted master drops s_valid 3 cycles mid-burst while master1 requests -> m_valid=0 those cycles, grant unchanged.
//  6) rst pulled low during beat 2 of a burst -> IDLE, m_valid=0 same cycle; PRIO_EN build: high_prio=2'b10 -> master1 first.

Source files
------------

// File: rtl/versat_databus_arbiter_pkg.sv
// Shared types and constants for the Versat databus arbiter slice.
package versat_databus_arbiter_pkg;

    localparam int unsigned IO_ADDR_W = 32;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Grant index width, never below one bit even for a single master.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/versat_databus_arbiter_if.sv
// Databus bundle between the IO-unit side (s_*) and the memory side (m_*).
interface versat_databus_arbiter_if #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = versat_databus_arbiter_pkg::IO_ADDR_W
);

    logic [N_MASTERS-1:0]          s_valid;
    logic [N_MASTERS-1:0]          s_ready;
    logic [N_MASTERS*ADDR_W-1:0]   s_addr;
    logic [N_MASTERS*DATA_W-1:0]   s_wdata;
    logic [N_MASTERS*DATA_W/8-1:0] s_wstrb;
    logic [N_MASTERS*8-1:0]        s_len;
    logic [DATA_W-1:0]             s_rdata;
    logic [N_MASTERS-1:0]          s_last;

    logic                          m_valid;
    logic                          m_ready;
    logic [ADDR_W-1:0]             m_addr;
    logic [DATA_W-1:0]             m_wdata;
    logic [DATA_W/8-1:0]           m_wstrb;
    logic [7:0]                    m_len;
    logic [DATA_W-1:0]             m_rdata;
    logic                          m_last;

    // Arbiter view: receives requests and memory responses.
    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb, s_len, m_ready, m_rdata, m_last,
        output s_ready, s_rdata, s_last, m_valid, m_addr, m_wdata, m_wstrb, m_len
    );

    // Environment view: IO units plus system memory.
    modport master (
        output s_valid, s_addr, s_wdata, s_wstrb, s_len, m_ready, m_rdata, m_last,
        input  s_ready, s_rdata, s_last, m_valid, m_addr, m_wdata, m_wstrb, m_len
    );

endinterface

// File: rtl/versat_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module versat_rr_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/versat_databus_arbiter.sv
// Burst-locked round-robin arbiter sharing one memory databus among N IO units.
// Optional VERSAT_ARB_PRIO_EN adds a high_prio input that narrows arbitration.
module versat_databus_arbiter
    import versat_databus_arbiter_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 2,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned ADDR_W    = IO_ADDR_W,
    localparam int unsigned IDX_W     = idx_width(N_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef VERSAT_ARB_PRIO_EN
    input  logic [N_MASTERS-1:0]   high_prio,
`endif
    versat_databus_arbiter_if.slave bus,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_MASTERS-1:0] pick_req;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 burst_end;

`ifdef VERSAT_ARB_PRIO_EN
    logic [N_MASTERS-1:0] hot_req;
    assign hot_req  = bus.s_valid & high_prio;
    assign pick_req = (|hot_req) ? hot_req : bus.s_valid;
`else
    assign pick_req = bus.s_valid;
`endif

    versat_rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (pick_req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Only a handshaked last beat closes the burst; a bare m_last is ignored.
    assign burst_end = (state_q == ARB_BURST) & bus.m_valid & bus.m_ready & bus.m_last;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                if (burst_end) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.m_valid = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        bus.m_len   = '0;
        bus.s_ready = '0;
        bus.s_last  = '0;
        bus.s_rdata = bus.m_rdata;
        if (state_q == ARB_BURST) begin
            for (int unsigned k = 0; k < N_MASTERS; k++) begin
                if (grant_q == IDX_W'(k)) begin
                    bus.m_valid   = bus.s_valid[k];
                    bus.m_addr    = bus.s_addr[k*ADDR_W +: ADDR_W];
                    bus.m_wdata   = bus.s_wdata[k*DATA_W +: DATA_W];
                    bus.m_wstrb   = bus.s_wstrb[k*(DATA_W/8) +: DATA_W/8];
                    bus.m_len     = bus.s_len[k*8 +: 8];
                    bus.s_ready[k] = bus.m_ready;
                    bus.s_last[k]  = bus.m_last;
                end
            end
        end
    end

    assign busy      = (state_q == ARB_BURST);
    assign grant_idx = grant_q;

endmodule
